rgb_pwm_gen: RTL and testbench
==============================

Name: rgb_pwm_gen

Overview:
Generates the three PWM enable waveforms that drive the on-chip RGB LED current driver, from 8-bit-class duty values written by a control master.
- Duty updates pass through a shadow register and apply only at a PWM period boundary, so no glitched partial periods occur.
- An optional fade mode steps each channel by one LSB per period toward the new target.
- Sits between the control/register logic and the RGB LED driver block.

Parameters:
PWM_BITS, 8, width of the duty values and the PWM counter; period = 2^PWM_BITS ticks.
PRESCALE, 1, i_clk cycles per PWM tick; legal range 1 to 65535.

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
i_wr_valid  input  1  new duty triple offered
o_wr_ready  output  1  shadow register empty; write accepted when i_wr_valid && o_wr_ready
i_wr_r  input  PWM_BITS  red duty target
i_wr_g  input  PWM_BITS  green duty target
i_wr_b  input  PWM_BITS  blue duty target
i_fade_en  input  1  1 = ramp toward target by 1 LSB per period; 0 = jump
o_r  output  1  red PWM enable, to the LED driver
o_g  output  1  green PWM enable
o_b  output  1  blue PWM enable
o_period_start  output  1  one-cycle pulse at the start of each PWM period

Behaviour:
Clock and reset:
- Single clock i_clk; reset i_rst is synchronous and active-high.

Reset state (cycle after i_rst is sampled high):
- Prescaler = 0, PWM counter = 0.
- Active duties = 0, shadow duties = 0, pending = 0.
- o_r/o_g/o_b = 0, o_period_start = 0, o_wr_ready = 1.
- A reset mid-fade or with a pending update discards all state.

Prescaler and tick:
- Counts 0..PRESCALE-1.
- tick = (prescaler == PRESCALE-1). With PRESCALE = 1, tick is asserted every cycle.

PWM counter:
- Advances only on tick; counts 0..2^PWM_BITS-1, then wraps to 0.
- wrap = tick && counter == 2^PWM_BITS-1.

Outputs:
- Registered: o_x <= (counter < active_x), evaluated every cycle. This gives one cycle of latency from counter to pin.
- Duty 0 → constant 0.
- Duty 2^PWM_BITS-1 → high for (2^PWM_BITS-1) of 2^PWM_BITS ticks. 100% is not reachable by design.
- o_period_start <= wrap. It is high in the first cycle where counter == 0.

Write handshake:
- o_wr_ready = !pending (driven from a register, no combinational path from i_wr_valid).
- On accept: shadow <= {i_wr_r, i_wr_g, i_wr_b}, pending <= 1.
- Inputs are ignored when i_wr_valid && !o_wr_ready. The master must hold valid until accepted.

Update at wrap (pending = 1 only); i_fade_en is sampled at the wrap:
- Jump (i_fade_en = 0): active <= shadow; pending <= 0.
- Fade (i_fade_en = 1): each active_x moves 1 toward shadow_x (+1, -1, or unchanged if equal). pending <= 0 in the same wrap where all three post-step values equal shadow. Otherwise pending stays set and o_wr_ready stays low.
- Clearing i_fade_en mid-fade: the next wrap jumps to the target.

Simultaneous events:
- Accept and wrap in the same cycle: only possible with pending = 0, so the wrap makes no change. The new value applies at the following wrap.
- Writing a target equal to the current active value still sets pending. The next wrap clears it with no visible change.

Arithmetic:
- Fade steps saturate at the target value; no overflow or underflow past 0 or 2^PWM_BITS-1.

Apply latency:
- The new duty becomes visible on the pins 1 cycle after the wrap that applies it.

Test Plan:
- Reset (PWM_BITS=8, PRESCALE=1): assert i_rst for 2 cycles → o_r/g/b = 0, o_period_start = 0, o_wr_ready = 1; first o_period_start pulse 256 cycles after reset release.
- Write r=64, g=0, b=255, fade off → pending until next wrap; in every subsequent 256-cycle period o_r is high exactly 64 cycles starting at period start, o_g is never high, and o_b is high 255 cycles.
- Back-to-back writes (r=10, then r=200 offered immediately) → o_wr_ready low after the first accept; the second is accepted the cycle after the wrap; period N+1 shows o_r high for 10 cycles, and the period after the next wrap shows 200.
- Fade 0 → r=3, fade on → o_r high counts of 1, 2, 3 in three successive periods; o_wr_ready returns to 1 in the cycle after the third wrap.
- PRESCALE=4 → o_period_start spacing of exactly 1024 cycles; r=128 gives o_r high for 512 consecutive cycles per period.
- Reset asserted mid-fade (active r = 2, target 100) → next cycle all outputs 0, o_wr_ready = 1, and the duty stays 0 after release.

Source files
------------

// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM generator for the RGB LED driver. Duty writes land in a
// shadow register and reach the active duties only at a PWM period boundary.
module rgb_pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_valid,
    output logic                o_wr_ready,
    input  logic [PWM_BITS-1:0] i_wr_r,
    input  logic [PWM_BITS-1:0] i_wr_g,
    input  logic [PWM_BITS-1:0] i_wr_b,
    input  logic                i_fade_en,
    output logic                o_r,
    output logic                o_g,
    output logic                o_b,
    output logic                o_period_start
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] counter;
    logic                tick;
    logic                wrap;

    logic [PWM_BITS-1:0] active_r, active_g, active_b;
    logic [PWM_BITS-1:0] shadow_r, shadow_g, shadow_b;
    logic [PWM_BITS-1:0] step_r, step_g, step_b;
    logic                pending;
    logic                fade_done;

    // Move one LSB toward the target; equal values stay put, so the step can
    // never overshoot the target or run past either end of the range.
    function automatic logic [PWM_BITS-1:0] fade_step(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt
    );
        if (cur < tgt) begin
            return cur + PWM_BITS'(1);
        end else if (cur > tgt) begin
            return cur - PWM_BITS'(1);
        end else begin
            return cur;
        end
    endfunction

    assign tick = (prescaler == PS_LAST);
    assign wrap = tick && (counter == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prescaler <= '0;
            counter   <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            if (tick) begin
                counter <= counter + PWM_BITS'(1);
            end
        end
    end

    always_comb begin
        step_r    = fade_step(active_r, shadow_r);
        step_g    = fade_step(active_g, shadow_g);
        step_b    = fade_step(active_b, shadow_b);
        fade_done = (step_r == shadow_r) && (step_g == shadow_g) && (step_b == shadow_b);
    end

    // Handshake: a write transfers on any clock edge where i_wr_valid and
    // o_wr_ready are both high; the master holds valid and data until then.
    // Ready is the inverse of the pending flop, so it never depends on valid.
    assign o_wr_ready = !pending;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending  <= 1'b0;
            shadow_r <= '0;
            shadow_g <= '0;
            shadow_b <= '0;
            active_r <= '0;
            active_g <= '0;
            active_b <= '0;
        end else if (i_wr_valid && !pending) begin
            shadow_r <= i_wr_r;
            shadow_g <= i_wr_g;
            shadow_b <= i_wr_b;
            pending  <= 1'b1;
        end else if (wrap && pending) begin
            if (i_fade_en) begin
                active_r <= step_r;
                active_g <= step_g;
                active_b <= step_b;
                pending  <= !fade_done;
            end else begin
                active_r <= shadow_r;
                active_g <= shadow_g;
                active_b <= shadow_b;
                pending  <= 1'b0;
            end
        end
    end

    // Registered pins: one cycle from counter to LED enable, glitch-free.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_r            <= 1'b0;
            o_g            <= 1'b0;
            o_b            <= 1'b0;
            o_period_start <= 1'b0;
        end else begin
            o_r            <= (counter < active_r);
            o_g            <= (counter < active_g);
            o_b            <= (counter < active_b);
            o_period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Self-checking bench for rgb_pwm_gen: per-period high counts are predicted
// from the written duties and compared through an expected-value queue.
module tb_rgb_pwm_gen;

    localparam int PERIOD = 256;
    localparam int BUDGET = 3000;

    typedef struct {
        logic [7:0] r, g, b;
        int         er, eg, eb;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid, fade_en, wr_ready;
    logic [7:0] wr_r, wr_g, wr_b;
    logic       o_r, o_g, o_b, pstart;

    logic       w4_valid, w4_ready, fade4;
    logic [7:0] w4_r, w4_g, w4_b;
    logic       r4, g4, b4, pstart4;

    logic [47:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rgb_pwm_gen #(.PWM_BITS(8), .PRESCALE(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_r(wr_r), .i_wr_g(wr_g), .i_wr_b(wr_b), .i_fade_en(fade_en),
        .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_period_start(pstart)
    );

    rgb_pwm_gen #(.PWM_BITS(8), .PRESCALE(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(w4_valid), .o_wr_ready(w4_ready),
        .i_wr_r(w4_r), .i_wr_g(w4_g), .i_wr_b(w4_b), .i_fade_en(fade4),
        .o_r(r4), .o_g(g4), .o_b(b4), .o_period_start(pstart4)
    );

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wr_valid = 1'b0;
        w4_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        wr_r = r; wr_g = g; wr_b = b;
        wr_valid = 1'b1;
        while (!wr_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check("write_accept_timeout", 0, 1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    // Ready must return exactly in the period-start cycle of the applying wrap.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!wr_ready && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check({name, "_ready_timeout"}, 0, 1);
        check({name, "_pstart_at_ready"}, int'(pstart), 1);
    endtask

    task automatic wait_pstart(input string name);
        int n = 0;
        while (!pstart && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check({name, "_pstart_timeout"}, 0, 1);
    endtask

    // Called in a period-start cycle; samples the pins for one full period.
    task automatic count_period(output int cr, output int cg, output int cb);
        cr = 0; cg = 0; cb = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            cr += int'(o_r);
            cg += int'(o_g);
            cb += int'(o_b);
        end
    endtask

    task automatic push_exp(input int er, input int eg, input int eb);
        exp_q.push_back({16'(er), 16'(eg), 16'(eb)});
    endtask

    task automatic score(input string name, input int cr, input int cg, input int cb);
        logic [47:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_r_count"}, cr, int'(e[47:32]));
        check({name, "_g_count"}, cg, int'(e[31:16]));
        check({name, "_b_count"}, cb, int'(e[15:0]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        int   cr, cg, cb, n, hi, run, maxrun;

        vecs[0] = '{r: 8'd64,  g: 8'd0,   b: 8'd255, er: 64,  eg: 0,   eb: 255};
        vecs[1] = '{r: 8'd255, g: 8'd128, b: 8'd1,   er: 255, eg: 128, eb: 1};
        vecs[2] = '{r: 8'd0,   g: 8'd0,   b: 8'd0,   er: 0,   eg: 0,   eb: 0};
        vecs[3] = '{r: 8'd200, g: 8'd17,  b: 8'd200, er: 200, eg: 17,  eb: 200};
        vecs[4] = '{r: 8'd200, g: 8'd17,  b: 8'd200, er: 200, eg: 17,  eb: 200};

        rst = 1'b1; wr_valid = 1'b0; fade_en = 1'b0;
        wr_r = '0; wr_g = '0; wr_b = '0;
        w4_valid = 1'b0; fade4 = 1'b0; w4_r = '0; w4_g = '0; w4_b = '0;

        // Reset values, then first period-start pulse 256 cycles after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_o_r", int'(o_r), 0);
        check("rst_o_g", int'(o_g), 0);
        check("rst_o_b", int'(o_b), 0);
        check("rst_pstart", int'(pstart), 0);
        check("rst_ready", int'(wr_ready), 1);
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!pstart && n < BUDGET);
        check("first_pstart_latency", n, 256);

        // PRESCALE=4 instance: 1024-cycle periods, r=128 gives a 512-cycle run.
        @(negedge clk);
        w4_r = 8'd128;
        w4_valid = 1'b1;
        @(posedge clk);
        #1 w4_valid = 1'b0;
        n = 0;
        while (!pstart4 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) check("ps4_pstart_timeout", 0, 1);
        n = 0; hi = 0; run = 0; maxrun = 0;
        do begin
            @(negedge clk);
            n++;
            if (r4) begin
                hi++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end while (!pstart4 && n < BUDGET);
        check("ps4_period_spacing", n, 1024);
        check("ps4_r_high_total", hi, 512);
        check("ps4_r_high_run", maxrun, 512);

        // Table of jump-mode writes, the last one equal to the active value.
        fade_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_write(vecs[i].r, vecs[i].g, vecs[i].b);
            push_exp(vecs[i].er, vecs[i].eg, vecs[i].eb);
            check($sformatf("vec%0d_ready_low_after_accept", i), int'(wr_ready), 0);
            wait_ready($sformatf("vec%0d", i));
            count_period(cr, cg, cb);
            score($sformatf("vec%0d", i), cr, cg, cb);
        end

        // Back-to-back: second write waits for the wrap that applies the first.
        do_write(8'd10, 8'd0, 8'd0);
        push_exp(10, 0, 0);
        wr_r = 8'd200; wr_g = 8'd0; wr_b = 8'd0;
        wr_valid = 1'b1;
        @(negedge clk);
        check("b2b_ready_low", int'(wr_ready), 0);
        wait_ready("b2b_first");
        @(posedge clk);
        #1 wr_valid = 1'b0;
        count_period(cr, cg, cb);
        score("b2b_first", cr, cg, cb);
        push_exp(200, 0, 0);
        wait_ready("b2b_second");
        count_period(cr, cg, cb);
        score("b2b_second", cr, cg, cb);

        // Fade 0 -> 3: one LSB per period, ready back only after the third wrap.
        do_reset();
        fade_en = 1'b1;
        do_write(8'd3, 8'd0, 8'd0);
        push_exp(1, 0, 0);
        push_exp(2, 0, 0);
        push_exp(3, 0, 0);
        wait_pstart("fade");
        for (int k = 0; k < 3; k++) begin
            check($sformatf("fade%0d_ready", k), int'(wr_ready), (k == 2) ? 1 : 0);
            count_period(cr, cg, cb);
            score($sformatf("fade%0d", k), cr, cg, cb);
        end

        // Dropping fade mid-ramp makes the next wrap jump to the target.
        do_write(8'd100, 8'd0, 8'd0);
        wait_pstart("fade_clear");
        fade_en = 1'b0;
        push_exp(4, 0, 0);
        count_period(cr, cg, cb);
        score("fade_clear_step", cr, cg, cb);
        push_exp(100, 0, 0);
        wait_ready("fade_clear_jump");
        count_period(cr, cg, cb);
        score("fade_clear_jump", cr, cg, cb);

        // Reset in the middle of a fade discards active and pending state.
        do_reset();
        fade_en = 1'b1;
        do_write(8'd100, 8'd0, 8'd0);
        wait_pstart("midrst");
        push_exp(1, 0, 0);
        count_period(cr, cg, cb);
        score("midrst_step", cr, cg, cb);
        @(negedge clk);
        check("midrst_r_high_before", int'(o_r), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_o_r", int'(o_r), 0);
        check("midrst_o_g", int'(o_g), 0);
        check("midrst_o_b", int'(o_b), 0);
        check("midrst_pstart", int'(pstart), 0);
        check("midrst_ready", int'(wr_ready), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fade_en = 1'b0;
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            hi += int'(o_r);
        end
        check("midrst_r_stays_zero", hi, 0);
        check("midrst_ready_after", int'(wr_ready), 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
